vga_timing_gen: RTL and testbench
=================================

VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 The module SHALL have parameter CLK_DIV, default 4: system clocks per pixel (100 MHz to 25 MHz).
REQ-002 The module SHALL have parameter H_TOTAL, default 800: pixel ticks per line.
REQ-003 The module SHALL have parameter H_SYNC, default 96: hSync is low while hCount < H_SYNC.
REQ-004 The module SHALL have parameters H_BRIGHT_START, default 144, and H_BRIGHT_END, default 784: the visible hCount range is [start, end).
REQ-005 The module SHALL have parameter V_TOTAL, default 525: lines per frame.
REQ-006 The module SHALL have parameter V_SYNC, default 2: vSync is low while vCount < V_SYNC.
REQ-007 The module SHALL have parameters V_BRIGHT_START, default 35, and V_BRIGHT_END, default 515: the visible vCount range is [start, end).
REQ-008 The module SHALL have port clk, input, 1 bit: the single system clock; all logic is on the rising edge.
REQ-009 The module SHALL have port rst, input, 1 bit: synchronous reset, active-high.
REQ-010 The module SHALL have port hCount, output, 10 bits: horizontal pixel counter.
REQ-011 The module SHALL have port vCount, output, 10 bits: vertical line counter.
REQ-012 The module SHALL have ports hSync and vSync, outputs, 1 bit each: active-low sync pulses.
REQ-013 The module SHALL have port bright, output, 1 bit: high inside the visible window.
REQ-014 The module SHALL have port pixel_tick, output, 1 bit: one-clk pulse on each clk where the counters advance.
REQ-015 The module SHALL have port frame_start, output, 1 bit: one-clk pulse when the counters become (0,0).
REQ-016 The module SHALL have port vblank_start, output, 1 bit: one-clk pulse when vCount becomes V_BRIGHT_END with hCount 0; this is the safe point for keySelect/level updates.

Function
REQ-017 A divider counter SHALL count 0..CLK_DIV-1 and wrap; pixel_tick SHALL be high on the clk in which the counter equals CLK_DIV-1.
REQ-018 hCount/vCount SHALL change only on pixel_tick clocks and SHALL hold on all other clocks.
REQ-019 On a tick, hCount SHALL increment, and SHALL wrap from H_TOTAL-1 to 0.
REQ-020 On a tick with hCount = H_TOTAL-1, vCount SHALL increment, and SHALL wrap from V_TOTAL-1 to 0 on that same tick.
REQ-021 hSync, vSync, bright, frame_start and vblank_start SHALL be registered and computed from the next counter values, so that they change on the same clk edge as hCount/vCount, with zero skew.
REQ-022 hSync SHALL equal (hCount >= H_SYNC) and vSync SHALL equal (vCount >= V_SYNC).
REQ-023 bright SHALL equal hCount in [H_BRIGHT_START, H_BRIGHT_END) AND vCount in [V_BRIGHT_START, V_BRIGHT_END).
REQ-024 frame_start and vblank_start SHALL be high for exactly one clk: the clk immediately after the edge that loads the qualifying counter values.
REQ-025 At the default parameters, the frame period SHALL be 800 x 525 x 4 = 1,680,000 clk.
REQ-026 Counter arithmetic SHALL be 10-bit unsigned and SHALL never exceed TOTAL-1.
REQ-027 The default parameters SHALL give a visible area of 640 x 480, with pixel (0,0) at hCount 144, vCount 35.

Reset
REQ-028 While rst is high at a clk edge, the module SHALL set: divider = 0, hCount = 0, vCount = 0, hSync = 0, vSync = 0, bright = 0, pixel_tick = 0, frame_start = 0, vblank_start = 0.
REQ-029 Reset asserted mid-line or mid-frame SHALL take effect at the next edge with no partial pulse.
REQ-030 After rst falls, the first pixel_tick SHALL occur CLK_DIV clocks later.
REQ-031 The reset state (0,0) SHALL NOT itself raise frame_start; the first frame_start SHALL be at the first wrap to (0,0).

Structure
REQ-032 Package vga_timing_pkg SHALL hold the default H_*/V_* timing constants and the counter width of 10, shared with the pixel renderer.
REQ-033 The divider SHALL be one sub-module, pixel_tick_gen (params CLK_DIV; ports clk, rst, tick).
REQ-034 All other logic SHALL be flat in vga_timing_gen.
REQ-035 The module SHALL have no combinational path from any input to any output.

Verification
REQ-036 Reset then release: pixel_tick SHALL be high at clk 4, 8, 12 after release, and hCount SHALL read 1 after the first tick.
REQ-037 Run one line: at hCount 95 -> 96 hSync SHALL rise; at 143 -> 144 bright SHALL rise (once vCount >= 35); at 783 -> 784 bright SHALL fall; at 799 -> 0 vCount SHALL increment.
REQ-038 Run a full frame: vSync SHALL be low exactly for lines 0-1; frame_start SHALL pulse once, 1,680,000 clk after the previous one.
REQ-039 vblank_start SHALL pulse exactly once per frame, at vCount = 515, hCount = 0; bright SHALL be 0 for all of lines 515-524 and 0-34.
REQ-040 Assert rst for 1 clk at hCount 400, vCount 200: on the next clk all outputs SHALL be 0, and no frame_start or vblank_start SHALL occur.
REQ-041 Across a full frame, the bench SHALL count exactly 640 x 480 = 307,200 ticks with bright high.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// VGA timing constants shared by the timing generator and the pixel renderer.
// Defaults describe 640x480 at 60 Hz from a 100 MHz system clock.
package vga_timing_pkg;

    localparam int CNT_W = 10;

    localparam int CLK_DIV_D        = 4;
    localparam int H_TOTAL_D        = 800;
    localparam int H_SYNC_D         = 96;
    localparam int H_BRIGHT_START_D = 144;
    localparam int H_BRIGHT_END_D   = 784;
    localparam int V_TOTAL_D        = 525;
    localparam int V_SYNC_D         = 2;
    localparam int V_BRIGHT_START_D = 35;
    localparam int V_BRIGHT_END_D   = 515;

    typedef logic [CNT_W-1:0] cnt_t;

    function automatic cnt_t to_cnt(input int v);
        return cnt_t'(v);
    endfunction

endpackage

// File: rtl/pixel_tick_gen.sv
// Divides the system clock down to one registered pulse per pixel.
// The pulse is high during the clock in which the divider sits at CLK_DIV-1.
module pixel_tick_gen #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DW-1:0] LAST = DW'(CLK_DIV - 1);

    logic [DW-1:0] r_div;
    logic [DW-1:0] w_div_nxt;
    logic          r_tick;

    always_comb begin
        w_div_nxt = r_div + 1'b1;
        if (r_div == LAST) begin
            w_div_nxt = '0;
        end
    end

    // Registering the decode keeps tick low during reset and glitch-free.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_div  <= '0;
            r_tick <= 1'b0;
        end else begin
            r_div  <= w_div_nxt;
            r_tick <= (w_div_nxt == LAST);
        end
    end

    assign tick = r_tick;

endmodule

// File: rtl/vga_timing_gen.sv
// VGA horizontal/vertical counters with registered sync, blanking and frame events.
// All decoded outputs are computed from next counter values so they align with the counters.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int CLK_DIV        = CLK_DIV_D,
    parameter int H_TOTAL        = H_TOTAL_D,
    parameter int H_SYNC         = H_SYNC_D,
    parameter int H_BRIGHT_START = H_BRIGHT_START_D,
    parameter int H_BRIGHT_END   = H_BRIGHT_END_D,
    parameter int V_TOTAL        = V_TOTAL_D,
    parameter int V_SYNC         = V_SYNC_D,
    parameter int V_BRIGHT_START = V_BRIGHT_START_D,
    parameter int V_BRIGHT_END   = V_BRIGHT_END_D
) (
    input  logic             clk,
    input  logic             rst,
    output logic [CNT_W-1:0] hCount,
    output logic [CNT_W-1:0] vCount,
    output logic             hSync,
    output logic             vSync,
    output logic             bright,
    output logic             pixel_tick,
    output logic             frame_start,
    output logic             vblank_start
);

    localparam cnt_t H_LAST = to_cnt(H_TOTAL - 1);
    localparam cnt_t V_LAST = to_cnt(V_TOTAL - 1);
    localparam cnt_t HS     = to_cnt(H_SYNC);
    localparam cnt_t VS     = to_cnt(V_SYNC);
    localparam cnt_t HBS    = to_cnt(H_BRIGHT_START);
    localparam cnt_t HBE    = to_cnt(H_BRIGHT_END);
    localparam cnt_t VBS    = to_cnt(V_BRIGHT_START);
    localparam cnt_t VBE    = to_cnt(V_BRIGHT_END);
    localparam cnt_t ONE    = to_cnt(1);

    logic w_tick;
    cnt_t r_h;
    cnt_t r_v;
    cnt_t w_h_nxt;
    cnt_t w_v_nxt;
    logic r_hs;
    logic r_vs;
    logic r_bright;
    logic r_fs;
    logic r_vb;

    pixel_tick_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_tick (
        .clk  (clk),
        .rst  (rst),
        .tick (w_tick)
    );

    always_comb begin
        w_h_nxt = r_h;
        w_v_nxt = r_v;
        if (w_tick) begin
            if (r_h == H_LAST) begin
                w_h_nxt = '0;
                w_v_nxt = (r_v == V_LAST) ? '0 : r_v + ONE;
            end else begin
                w_h_nxt = r_h + ONE;
            end
        end
    end

    // Event pulses qualify on w_tick so the reset state never looks like a wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_h      <= '0;
            r_v      <= '0;
            r_hs     <= 1'b0;
            r_vs     <= 1'b0;
            r_bright <= 1'b0;
            r_fs     <= 1'b0;
            r_vb     <= 1'b0;
        end else begin
            r_h      <= w_h_nxt;
            r_v      <= w_v_nxt;
            r_hs     <= (w_h_nxt >= HS);
            r_vs     <= (w_v_nxt >= VS);
            r_bright <= (w_h_nxt >= HBS) && (w_h_nxt < HBE)
                     && (w_v_nxt >= VBS) && (w_v_nxt < VBE);
            r_fs     <= w_tick && (w_h_nxt == '0) && (w_v_nxt == '0);
            r_vb     <= w_tick && (w_h_nxt == '0) && (w_v_nxt == VBE);
        end
    end

    assign hCount       = r_h;
    assign vCount       = r_v;
    assign hSync        = r_hs;
    assign vSync        = r_vs;
    assign bright       = r_bright;
    assign pixel_tick   = w_tick;
    assign frame_start  = r_fs;
    assign vblank_start = r_vb;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: default-timing instance for line events, reduced instance for frames.
// Reduced timing: div 2, 40x20 total, hsync 6, h visible [10,34), vsync 2, v visible [4,16).
module tb_vga_timing_gen;

    logic clk = 1'b0;
    logic rst_d;
    logic rst_s;

    logic [9:0] d_h, d_v, s_h, s_v;
    logic d_hs, d_vs, d_br, d_tick, d_fs, d_vb;
    logic s_hs, s_vs, s_br, s_tick, s_fs, s_vb;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    vga_timing_gen u_def (
        .clk          (clk),
        .rst          (rst_d),
        .hCount       (d_h),
        .vCount       (d_v),
        .hSync        (d_hs),
        .vSync        (d_vs),
        .bright       (d_br),
        .pixel_tick   (d_tick),
        .frame_start  (d_fs),
        .vblank_start (d_vb)
    );

    vga_timing_gen #(
        .CLK_DIV        (2),
        .H_TOTAL        (40),
        .H_SYNC         (6),
        .H_BRIGHT_START (10),
        .H_BRIGHT_END   (34),
        .V_TOTAL        (20),
        .V_SYNC         (2),
        .V_BRIGHT_START (4),
        .V_BRIGHT_END   (16)
    ) u_sm (
        .clk          (clk),
        .rst          (rst_s),
        .hCount       (s_h),
        .vCount       (s_v),
        .hSync        (s_hs),
        .vSync        (s_vs),
        .bright       (s_br),
        .pixel_tick   (s_tick),
        .frame_start  (s_fs),
        .vblank_start (s_vb)
    );

    task automatic step(input int n = 1);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    int cnt;
    int n_vs_low, n_hs_low, n_bt, n_fs, n_vb, n_blank_br, n_br_bad, n_ev;
    logic [9:0] vb_h, vb_v;

    initial begin
        rst_d = 1'b1;
        rst_s = 1'b1;
        step(2);

        chk("rst_hcount", d_h, 0);
        chk("rst_vcount", d_v, 0);
        chk("rst_hsync", d_hs, 0);
        chk("rst_vsync", d_vs, 0);
        chk("rst_bright", d_br, 0);
        chk("rst_tick", d_tick, 0);
        chk("rst_frame_start", d_fs, 0);
        chk("rst_vblank_start", d_vb, 0);

        // Release: ticks in clocks 4, 8, 12 after release.
        rst_d = 1'b0;
        for (int n = 1; n <= 12; n++) begin
            step();
            chk($sformatf("tick_clk%0d", n + 1), d_tick, (n % 4) == 3);
            if (n == 4) chk("h_after_first_tick", d_h, 1);
        end
        chk("h_after_3_ticks", d_h, 3);

        step(368);
        chk("h_95", d_h, 95);
        chk("hsync_low_95", d_hs, 0);
        step(3);
        chk("h_95_hold", d_h, 95);
        chk("hsync_hold_low", d_hs, 0);
        step();
        chk("h_96", d_h, 96);
        chk("hsync_rise_96", d_hs, 1);

        step(192);
        chk("h_144", d_h, 144);
        chk("bright_low_line0", d_br, 0);

        step(2620);
        chk("h_799", d_h, 799);
        chk("v_line0", d_v, 0);
        step();
        chk("h_799_hold", d_h, 799);
        step(3);
        chk("h_wrap_0", d_h, 0);
        chk("v_inc_1", d_v, 1);
        chk("hsync_low_wrap", d_hs, 0);
        chk("vsync_low_line1", d_vs, 0);
        chk("no_fs_line_wrap", d_fs, 0);
        rst_d = 1'b1;

        // Reduced instance: first frame_start is the first wrap, not reset.
        rst_s = 1'b0;
        cnt = 0;
        do begin
            step();
            cnt++;
        end while (!s_fs && cnt < 4000);
        chk("first_fs_clocks", cnt, 1600);
        chk("fs_at_h0", s_h, 0);
        chk("fs_at_v0", s_v, 0);

        n_vs_low = 0; n_hs_low = 0; n_bt = 0; n_fs = 0;
        n_vb = 0; n_blank_br = 0; n_br_bad = 0;
        vb_h = '1; vb_v = '1;
        for (int i = 0; i < 1600; i++) begin
            if (!s_vs) n_vs_low++;
            if (!s_hs) n_hs_low++;
            if (s_tick && s_br) n_bt++;
            if (s_fs) n_fs++;
            if (s_vb) begin
                n_vb++;
                vb_h = s_h;
                vb_v = s_v;
            end
            if (s_br && (s_v < 4 || s_v >= 16)) n_blank_br++;
            if (s_br !== ((s_h >= 10) && (s_h < 34) && (s_v >= 4) && (s_v < 16)))
                n_br_bad++;
            step();
        end
        chk("frame_period_fs", s_fs, 1);
        chk("fs_per_frame", n_fs, 1);
        chk("vsync_low_clocks", n_vs_low, 160);
        chk("hsync_low_clocks", n_hs_low, 240);
        chk("bright_ticks", n_bt, 288);
        chk("vblank_per_frame", n_vb, 1);
        chk("vblank_h", vb_h, 0);
        chk("vblank_v", vb_v, 16);
        chk("bright_in_vblank", n_blank_br, 0);
        chk("bright_window", n_br_bad, 0);

        // Mid-frame reset at (20, 8), inside the visible window.
        step(680);
        chk("mid_h", s_h, 20);
        chk("mid_v", s_v, 8);
        chk("mid_bright", s_br, 1);
        chk("mid_hsync", s_hs, 1);
        chk("mid_vsync", s_vs, 1);
        rst_s = 1'b1;
        step();
        rst_s = 1'b0;
        chk("mrst_h", s_h, 0);
        chk("mrst_v", s_v, 0);
        chk("mrst_hsync", s_hs, 0);
        chk("mrst_vsync", s_vs, 0);
        chk("mrst_bright", s_br, 0);
        chk("mrst_tick", s_tick, 0);
        chk("mrst_fs", s_fs, 0);
        chk("mrst_vb", s_vb, 0);
        step();
        chk("mrst_first_tick", s_tick, 1);
        chk("mrst_h_hold", s_h, 0);
        step();
        chk("mrst_h_1", s_h, 1);
        n_ev = 0;
        for (int i = 0; i < 50; i++) begin
            if (s_fs || s_vb) n_ev++;
            step();
        end
        chk("mrst_no_events", n_ev, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
